// File: rtl/mem_access_ctrl_if.sv
// System-bus side of the MEM-stage access controller: word-wide req/ack bus.
// master = controller, slave = bus bridge (or its model).
interface mem_access_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
                  input  bus_ack, bus_rdata, bus_err);
  modport slave  (input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
                  output bus_ack, bus_rdata, bus_err);
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: alignment trap, byte enables, store lane
// replication, load lane select/extension. Define MEM_TIMEOUT_EN for bus-ack timeout.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [1:0]  op_width,
  input  logic        load_signed,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_done,
  output logic        addr_err,
  output logic        bus_fault,
  mem_access_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

  typedef struct packed {
    logic [1:0] lane;
    logic [1:0] width;
    logic       sgn;
  } req_t;

  localparam logic [1:0] W_WORD = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..255");
  end

  state_t      state, state_n;
  req_t        req_q;
  logic        illegal;
  logic        timeout;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] ext;
  logic [15:0] half;
  logic [7:0]  bsel;

  always_comb begin
    illegal = 1'b0;
    be_n    = 4'b0000;
    wdata_n = mem_wdata;
    case (op_width)
      2'b00: begin
        illegal = |mem_addr[1:0];
        be_n    = 4'b1111;
      end
      2'b01: begin
        illegal = mem_addr[0];
        be_n    = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{mem_wdata[15:0]}};
      end
      2'b10: begin
        be_n    = 4'b0001 << mem_addr[1:0];
        wdata_n = {4{mem_wdata[7:0]}};
      end
      default: illegal = 1'b1;
    endcase
  end

  // Lane select uses the latched address bits; the live mem_* inputs may change in BUSY.
  always_comb begin
    half = req_q.lane[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    bsel = bus.bus_rdata[8*req_q.lane +: 8];
    case (req_q.width)
      W_WORD:  ext = bus.bus_rdata;
      W_HALF:  ext = {{16{req_q.sgn & half[15]}}, half};
      default: ext = {{24{req_q.sgn & bsel[7]}}, bsel};
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      to_cnt <= '0;
    else if (state == IDLE && state_n == BUSY)
      to_cnt <= '0;
    else if (state == BUSY && !bus.bus_ack)
      to_cnt <= to_cnt + 8'd1;
  end

  // Fires on the BUSY cycle whose increment would reach the limit; ack that cycle wins.
  assign timeout = (state == BUSY) && !bus.bus_ack && (to_cnt == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (mem_req) state_n = illegal ? ERR : BUSY;
      BUSY:    if (bus.bus_ack || timeout) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
      mem_rdata     <= '0;
      mem_done      <= 1'b0;
      addr_err      <= 1'b0;
      bus_fault     <= 1'b0;
      req_q         <= '0;
    end else begin
      mem_done  <= 1'b0;
      addr_err  <= 1'b0;
      bus_fault <= 1'b0;
      case (state)
        IDLE: if (mem_req) begin
          if (illegal) begin
            addr_err  <= 1'b1;
            mem_done  <= 1'b1;
            mem_rdata <= '0;
          end else begin
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= mem_we;
            bus.bus_addr  <= {mem_addr[31:2], 2'b00};
            bus.bus_be    <= be_n;
            bus.bus_wdata <= wdata_n;
            req_q         <= '{lane: mem_addr[1:0], width: op_width, sgn: load_signed};
          end
        end
        BUSY: if (bus.bus_ack) begin
          bus.bus_req <= 1'b0;
          mem_done    <= 1'b1;
          bus_fault   <= bus.bus_err;
          if (bus.bus_err)      mem_rdata <= '0;
          else if (!bus.bus_we) mem_rdata <= ext;
        end else if (timeout) begin
          bus.bus_req <= 1'b0;
          mem_done    <= 1'b1;
          bus_fault   <= 1'b1;
          mem_rdata   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign mem_stall = mem_req & ~(state == DONE || state == ERR);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: driver pushes expected results, a bus
// responder checks bus cycles, a monitor pops and compares on every mem_done.
module tb_mem_access_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_req = 1'b0, mem_we = 1'b0, load_signed = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [1:0]  op_width = '0;
  logic [31:0] mem_rdata;
  logic        mem_stall, mem_done, addr_err, bus_fault;

  mem_access_ctrl_if bus_if();

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .op_width(op_width),
    .load_signed(load_signed), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .mem_done(mem_done), .addr_err(addr_err), .bus_fault(bus_fault), .bus(bus_if));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        aerr;
    logic        fault;
    int          lat;
    int          issue;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    int          delay;
    logic [31:0] rword;
    logic        err;
    logic        noack;
    int          cycles;
  } bus_t;

  exp_t        exp_q[$];
  bus_t        bus_q[$];
  int          checks = 0, errors = 0;
  int          cyc = 0;
  logic [31:0] model_rd = '0;
  logic [31:0] held_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic finish_up();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Bus bridge model: acks after the configured wait, random stray acks while idle.
  bus_t cur;
  int   wcnt = 0;
  bit   active = 0;
  initial begin
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0; bus_if.bus_err = 1'b0;
    cur = '{default: 0};
  end

  always begin
    @(posedge clk); #1;
    if (!reset_n) begin
      bus_if.bus_ack = 1'b0; wcnt = 0; active = 0;
    end else if (bus_if.bus_req) begin
      if (!active) begin
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_unexpected: got bus_req=1 expected no bus cycle (cycle %0d)", cyc);
          cur = '{default: 0};
          cur.noack = 1'b1;
        end else begin
          cur = bus_q.pop_front();
          check("bus_addr", bus_if.bus_addr, cur.addr);
          check("bus_be", 32'(bus_if.bus_be), 32'(cur.be));
          check("bus_wdata", bus_if.bus_wdata, cur.wdata);
          check("bus_we", 32'(bus_if.bus_we), 32'(cur.we));
        end
        active = 1; wcnt = 0;
      end else if ({bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata, bus_if.bus_we} !==
                   {cur.addr, cur.be, cur.wdata, cur.we}) begin
        check("bus_hold", {bus_if.bus_addr[27:0], bus_if.bus_be}, {cur.addr[27:0], cur.be});
      end
      if (!cur.noack && wcnt == cur.delay) begin
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = cur.rword; bus_if.bus_err = cur.err;
      end else begin
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = $urandom; bus_if.bus_err = 1'($urandom);
      end
      wcnt++;
    end else begin
      if (active) check("bus_req_cycles", 32'(wcnt), 32'(cur.cycles));
      active = 0; wcnt = 0;
      bus_if.bus_ack = ($urandom % 4 == 0); bus_if.bus_rdata = $urandom; bus_if.bus_err = 1'($urandom);
    end
  end

  // Result monitor
  always @(negedge clk) begin
    if (reset_n) begin
      check("stall", 32'(mem_stall), 32'(mem_req & ~mem_done));
      if (mem_done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got mem_done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("mem_rdata", mem_rdata, e.rdata);
          check("addr_err", 32'(addr_err), 32'(e.aerr));
          check("bus_fault", 32'(bus_fault), 32'(e.fault));
          check("latency", 32'(cyc - e.issue), 32'(e.lat));
          held_rd = e.rdata;
        end
      end else begin
        check("rdata_hold", mem_rdata, held_rd);
        check("pulse_idle", {30'd0, addr_err, bus_fault}, 32'd0);
      end
    end
  end

  // Issue one access; expected result comes from byte-level arithmetic on the access rules.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] w, input logic sgn, input int delay,
                        input logic [31:0] rword, input logic berr, input logic noack,
                        input logic hold);
    int          off, nb, n;
    exp_t        e;
    bus_t        b;
    logic [31:0] mask, val;
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
    op_width = w; load_signed = sgn;
    off = int'(addr[1:0]);
    nb  = (w == 2'd0) ? 4 : (w == 2'd1) ? 2 : 1;
    e.issue = cyc;
    if (w == 2'd3 || (off % nb) != 0) begin
      e.aerr = 1'b1; e.fault = 1'b0; e.rdata = '0; e.lat = 1;
    end else begin
      b.addr = addr - 32'(off);
      b.be   = 4'(((1 << nb) - 1) << off);
      for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = wdata[8*(i % nb) +: 8];
      b.we = we; b.delay = delay; b.rword = rword; b.err = berr; b.noack = noack;
      e.aerr = 1'b0;
      if (TO_EN && (noack || delay >= TO)) begin
        b.cycles = TO; e.lat = TO + 1; e.fault = 1'b1; e.rdata = '0;
      end else begin
        b.cycles = delay + 1; e.lat = delay + 2; e.fault = berr;
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
        val  = (rword >> (8*off)) & mask;
        if (sgn && nb < 4 && val[8*nb-1]) val = val | ~mask;
        e.rdata = berr ? 32'd0 : (we ? model_rd : val);
      end
      bus_q.push_back(b);
    end
    model_rd = e.rdata;
    exp_q.push_back(e);
    n = 0;
    while (n < 600) begin
      @(negedge clk);
      if (mem_done) break;
      if (n > 0) begin
        mem_we = 1'($urandom); mem_addr = $urandom; mem_wdata = $urandom;
        op_width = 2'($urandom); load_signed = 1'($urandom);
      end
      n++;
    end
    if (n >= 600) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no mem_done expected one within 600 cycles");
      finish_up();
    end
    if (!hold) begin
      @(posedge clk); #1;
      mem_req = 1'b0;
    end
  endtask

  initial begin
    #500000;
    checks++; errors++;
    $display("FAIL watchdog: got simulation still running expected finish");
    finish_up();
  end

  initial begin
    #13;
    check("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
    check("rst_bus_addr", bus_if.bus_addr, 32'd0);
    check("rst_bus_be", 32'(bus_if.bus_be), 32'd0);
    check("rst_bus_wdata", bus_if.bus_wdata, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_flags", {28'd0, mem_done, addr_err, bus_fault, mem_stall}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Store word, signed/unsigned byte loads, half load with waits
    access(1, 32'h1004, 32'hDEADBEEF, 2'd0, 0, 0, 32'h0, 0, 0, 0);
    access(0, 32'h2003, 32'h0, 2'd2, 1, 0, 32'h80FF0011, 0, 0, 0);
    check("t2_signed", mem_rdata, 32'hFFFFFF80);
    access(0, 32'h2003, 32'h0, 2'd2, 0, 1, 32'h80FF0011, 0, 0, 0);
    check("t2_unsigned", mem_rdata, 32'h00000080);
    access(0, 32'h2002, 32'h0, 2'd1, 0, 3, 32'hABCD1234, 0, 0, 0);
    check("t3_half", mem_rdata, 32'h0000ABCD);
    access(1, 32'h2006, 32'h5555AAAA, 2'd1, 0, 2, 32'h0, 0, 0, 0);
    check("store_keeps_rdata", mem_rdata, 32'h0000ABCD);
    // Alignment traps
    access(0, 32'h3001, 32'h0, 2'd0, 0, 0, 32'h0, 0, 0, 0);
    check("t4_misalign", mem_rdata, 32'h0);
    access(0, 32'h2000, 32'h0, 2'd0, 0, 0, 32'h11223344, 0, 0, 0);
    access(0, 32'h3000, 32'h0, 2'd3, 0, 0, 32'h0, 0, 0, 0);
    check("t4_width11", mem_rdata, 32'h0);
    access(1, 32'h3005, 32'h0, 2'd1, 0, 0, 32'h0, 0, 0, 0);
    // Bus error with ack
    access(0, 32'h2000, 32'h0, 2'd0, 0, 0, 32'h11223344, 0, 0, 0);
    access(0, 32'h2000, 32'h0, 2'd0, 0, 1, 32'h99999999, 1, 0, 0);
    check("ack_err_rdata", mem_rdata, 32'h0);

    for (int i = 0; i < 80; i++)
      access(1'($urandom), $urandom, $urandom, 2'($urandom), 1'($urandom),
             int'($urandom % 4), $urandom, ($urandom % 8 == 0), 0, ($urandom % 4 == 0));
    @(posedge clk); #1 mem_req = 1'b0;
    repeat (2) @(posedge clk);

    // Reset while a store is outstanding on the bus
    #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h4000; mem_wdata = 32'hCAFEF00D; op_width = 2'd0;
    bus_q.push_back('{addr: 32'h4000, be: 4'hF, wdata: 32'hCAFEF00D, we: 1'b1, delay: 50,
                      rword: 32'h0, err: 1'b0, noack: 1'b1, cycles: 0});
    repeat (2) @(negedge clk);
    check("t5_busy", 32'(bus_if.bus_req), 32'd1);
    #2 reset_n = 1'b0; mem_req = 1'b0;
    #1;
    check("t5_bus_req", 32'(bus_if.bus_req), 32'd0);
    check("t5_bus_we", 32'(bus_if.bus_we), 32'd0);
    check("t5_bus_addr", bus_if.bus_addr, 32'd0);
    check("t5_bus_be", 32'(bus_if.bus_be), 32'd0);
    check("t5_bus_wdata", bus_if.bus_wdata, 32'd0);
    check("t5_outs", {mem_rdata[27:0], mem_done, addr_err, bus_fault, mem_stall}, 32'd0);
    bus_q.delete(); exp_q.delete();
    model_rd = '0; held_rd = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    access(0, 32'h2001, 32'h0, 2'd2, 1, 1, 32'h00007F00, 0, 0, 0);
    check("t5_after", mem_rdata, 32'h0000007F);

`ifdef MEM_TIMEOUT_EN
    access(0, 32'h6000, 32'h0, 2'd0, 0, TO - 1, 32'h0BADF00D, 0, 0, 0);
    check("t6_ack_at_limit", mem_rdata, 32'h0BADF00D);
    access(0, 32'h6004, 32'h0, 2'd0, 0, 0, 32'h0, 0, 1, 0);
    check("t6_timeout_rdata", mem_rdata, 32'h0);
    access(1, 32'h6008, 32'h12345678, 2'd2, 0, 0, 32'h0, 0, 1, 0);
`endif

    repeat (3) @(posedge clk);
    check("queues_drained", 32'(exp_q.size() + bus_q.size()), 32'd0);
    finish_up();
  end

endmodule
